// File: rtl/melody_sequencer.sv
// melody_sequencer: pitch/enable controller for the 3-bit tone divider.
// Plays a 16-entry song ROM (autoplay) or the lowest held key (manual).
// Ports: clk, rst_n (sync, active-low); key[7:0] manual keys;
//   start/stop pulses, loop_en; pitch[2:0], tone_en, busy, note_idx[3:0],
//   done (one-cycle end-of-song pulse). All outputs registered.
// Option: define MELODY_SEQUENCER_TEMPO_EN to add tempo[1:0] (tick >> tempo).
module melody_sequencer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_HZ   = 16,
  parameter int GAP_TICKS = 1,
  parameter int SONG_LEN  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
`ifdef MELODY_SEQUENCER_TEMPO_EN
  input  logic [1:0] tempo,
`endif
  output logic [2:0] pitch,
  output logic       tone_en,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DMAX = (GAP_TICKS > 16) ? GAP_TICKS : 16;
  localparam int DW = $clog2(DMAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [TW-1:0] DIV_M1 = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] GAP_D  = DW'(GAP_TICKS);
  localparam logic [3:0]    LAST   = 4'(SONG_LEN - 1);

  // {rest, pitch[2:0], dur[1:0]}
  function automatic logic [5:0] rom_entry(input logic [3:0] k);
    logic [3:0] t;
    t = 4'd15 - k;
    if (k < 4'd8)
      rom_entry = {1'b0, k[2:0], 2'd1};
    else if (k != 4'd15)
      rom_entry = {1'b0, t[2:0], 2'd0};
    else
      rom_entry = {1'b1, 3'd0, 2'd2};
  endfunction

  logic [1:0]    state, state_n;
  logic [3:0]    idx_n;
  logic [DW-1:0] dur, dur_n;
  logic [TW-1:0] tcnt, tcnt_n, per_m1;
  logic [5:0]    e_n;
  logic [2:0]    kidx, pitch_n;
  logic          paused, tick, adv, done_n;
  logic          ld_note, ld_gap, dec, tone_n;

`ifdef MELODY_SEQUENCER_TEMPO_EN
  logic [1:0] tempo_q;
  logic [TW:0] per_sh;
  logic start_ok;

  assign start_ok = (state == S_IDLE) && start && !stop && !paused;

  // Shifted period never drops below one cycle.
  always_comb begin
    per_sh = (TW+1)'(TICK_DIV) >> tempo_q;
    per_m1 = (per_sh == '0) ? '0 : TW'(per_sh - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      tempo_q <= '0;
    else if (start_ok)
      tempo_q <= tempo;
  end
`else
  assign per_m1 = DIV_M1;
`endif

  assign paused = |key;

  always_comb begin
    kidx = '0;
    for (int b = 7; b >= 0; b--)
      if (key[b]) kidx = 3'(b);
  end

  assign tick = (state != S_IDLE) && !paused && (tcnt == per_m1);

  always_comb begin
    if (state == S_IDLE || stop)
      tcnt_n = '0;
    else if (paused)
      tcnt_n = tcnt;
    else if (tick)
      tcnt_n = '0;
    else
      tcnt_n = tcnt + 1'b1;
  end

  always_comb begin
    state_n = state;
    idx_n   = note_idx;
    done_n  = 1'b0;
    adv     = 1'b0;
    ld_note = 1'b0;
    ld_gap  = 1'b0;
    dec     = 1'b0;
    if (stop) begin
      state_n = S_IDLE;
      idx_n   = '0;
      ld_note = 1'b1;
    end else if (!paused) begin
      case (state)
        S_PLAY: begin
          if (tick) begin
            if (dur == DW'(1)) begin
              if (GAP_TICKS > 0) begin
                state_n = S_GAP;
                ld_gap  = 1'b1;
              end else begin
                adv = 1'b1;
              end
            end else begin
              dec = 1'b1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (dur == DW'(1)) adv = 1'b1;
            else dec = 1'b1;
          end
        end
        default: begin
          state_n = start ? S_PLAY : S_IDLE;
          idx_n   = '0;
          ld_note = 1'b1;
        end
      endcase
      if (adv) begin
        ld_note = 1'b1;
        state_n = S_PLAY;
        if (note_idx < LAST) begin
          idx_n = note_idx + 4'd1;
        end else if (loop_en) begin
          idx_n = '0;
        end else begin
          state_n = S_IDLE;
          idx_n   = '0;
          done_n  = 1'b1;
        end
      end
    end
  end

  // Every duration load is for the entry that idx_n points at.
  always_comb begin
    e_n   = rom_entry(idx_n);
    dur_n = dur;
    if (ld_note)
      dur_n = DW'(5'd2 << e_n[1:0]);
    else if (ld_gap)
      dur_n = GAP_D;
    else if (dec)
      dur_n = dur - DW'(1);
  end

  always_comb begin
    if (paused)
      pitch_n = kidx;
    else if (state_n == S_IDLE)
      pitch_n = '0;
    else
      pitch_n = e_n[4:2];
    tone_n = paused | ((state_n == S_PLAY) & ~e_n[5]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      note_idx <= '0;
      dur      <= '0;
      tcnt     <= '0;
      pitch    <= '0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      note_idx <= idx_n;
      dur      <= dur_n;
      tcnt     <= tcnt_n;
      pitch    <= pitch_n;
      tone_en  <= tone_n;
      busy     <= (state_n != S_IDLE);
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: two configurations driven by shared stimulus,
// checked every cycle against a cycle-count song model.
module tb_melody_sequencer;
  localparam int TD = 10;

  logic clk = 1'b0;
  logic rst_n, start, stop, loop_en;
  logic [7:0] key;
`ifdef MELODY_SEQUENCER_TEMPO_EN
  logic [1:0] tempo;
`endif
  logic [2:0] pitch0, pitch1;
  logic tone0, tone1, busy0, busy1, done0, done1;
  logic [3:0] idx0, idx1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  melody_sequencer #(.CLK_FREQ(160), .TICK_HZ(16),
                     .GAP_TICKS(1), .SONG_LEN(2)) u0 (
    .clk(clk), .rst_n(rst_n), .key(key), .start(start),
    .stop(stop), .loop_en(loop_en),
`ifdef MELODY_SEQUENCER_TEMPO_EN
    .tempo(tempo),
`endif
    .pitch(pitch0), .tone_en(tone0), .busy(busy0),
    .note_idx(idx0), .done(done0));

  melody_sequencer #(.CLK_FREQ(160), .TICK_HZ(16),
                     .GAP_TICKS(0), .SONG_LEN(16)) u1 (
    .clk(clk), .rst_n(rst_n), .key(key), .start(start),
    .stop(stop), .loop_en(loop_en),
`ifdef MELODY_SEQUENCER_TEMPO_EN
    .tempo(tempo),
`endif
    .pitch(pitch1), .tone_en(tone1), .busy(busy1),
    .note_idx(idx1), .done(done1));

  // Song rules stated directly.
  function automatic int n_pitch(int k);
    if (k < 8) return k;
    if (k < 15) return 15 - k;
    return 0;
  endfunction
  function automatic int n_ticks(int k);
    if (k < 8) return 4;
    if (k < 15) return 2;
    return 8;
  endfunction

  // Model: mode 0 idle, 1 sounding note, 2 gap; rem = cycles left.
  int m_mode[2];
  int m_rem[2];
  int m_idx[2];
  int m_per[2];
  logic [9:0] m_exp[2];
  bit m_valid = 1'b0;
  int gapt[2] = '{1, 0};
  int slen[2] = '{2, 16};

  task automatic model_step(int i);
    int lk;
    bit paused, adv, dn;
    int p, t;
    lk = 0;
    for (int b = 7; b >= 0; b--) if (key[b]) lk = b;
    paused = (key != 8'd0);
    adv = 0;
    dn = 0;
    if (!rst_n) begin
      m_mode[i] = 0; m_idx[i] = 0; m_rem[i] = 0;
      m_exp[i] = '0;
      return;
    end
    if (stop) begin
      m_mode[i] = 0; m_idx[i] = 0;
    end else if (!paused) begin
      if (m_mode[i] == 0) begin
        if (start) begin
          m_per[i] = TD;
`ifdef MELODY_SEQUENCER_TEMPO_EN
          m_per[i] = TD >> tempo;
          if (m_per[i] < 1) m_per[i] = 1;
`endif
          m_mode[i] = 1; m_idx[i] = 0;
          m_rem[i] = n_ticks(0) * m_per[i];
        end
      end else begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          if (m_mode[i] == 1 && gapt[i] > 0) begin
            m_mode[i] = 2;
            m_rem[i] = gapt[i] * m_per[i];
          end else adv = 1;
        end
      end
      if (adv) begin
        if (m_idx[i] < slen[i] - 1) begin
          m_idx[i]++;
          m_mode[i] = 1;
        end else if (loop_en) begin
          m_idx[i] = 0;
          m_mode[i] = 1;
        end else begin
          m_mode[i] = 0; m_idx[i] = 0; dn = 1;
        end
        m_rem[i] = n_ticks(m_idx[i]) * m_per[i];
      end
    end
    if (paused) begin p = lk; t = 1; end
    else if (m_mode[i] == 0) begin p = 0; t = 0; end
    else begin
      p = n_pitch(m_idx[i]);
      t = (m_mode[i] == 1 && m_idx[i] != 15) ? 1 : 0;
    end
    m_exp[i] = {3'(p), 1'(t), (m_mode[i] != 0), 4'(m_idx[i]), dn};
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    m_valid = 1'b1;
  end

  task automatic compare_all();
    logic [9:0] act;
    if (!m_valid) return;
    for (int i = 0; i < 2; i++) begin
      act = (i == 0) ? {pitch0, tone0, busy0, idx0, done0}
                     : {pitch1, tone1, busy1, idx1, done1};
      n_chk++;
      if (act !== m_exp[i]) begin
        n_fail++;
        $display("FAIL model_cmp u%0d t=%0t got {p,t,b,i,d}=%h required %h",
                 i, $time, act, m_exp[i]);
      end
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0; step();
  endtask

  int on0, on1, sil, dcnt, pc, rc;
  bit got;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; key = '0;
`ifdef MELODY_SEQUENCER_TEMPO_EN
    tempo = 2'd0;
`endif
    step(); step();
    rst_n = 1'b1;
    chk("reset_u0", int'({pitch0, tone0, busy0, idx0, done0}), 0);
    chk("reset_u1", int'({pitch1, tone1, busy1, idx1, done1}), 0);

    // Two-note song with gaps.
    start = 1'b1; step(); start = 1'b0;
    chk("s1_busy", int'(busy0), 1);
    chk("s1_first", int'({pitch0, tone0}), 1);
    got = 0; on0 = 0; on1 = 0; sil = 0;
    for (int c = 0; c < 300; c++) begin
      if (done0) begin got = 1; break; end
      if (tone0 && pitch0 == 3'd0) on0++;
      if (tone0 && pitch0 == 3'd1) on1++;
      if (busy0 && !tone0) sil++;
      step();
    end
    chk("s1_done", int'(got), 1);
    chk("s1_on0", on0, 40);
    chk("s1_on1", on1, 40);
    chk("s1_gap", sil, 20);
    chk("s1_busy_end", int'(busy0), 0);
    pulse_stop();

    // Loop across the rest entry.
    loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    dcnt = 0; sil = 0;
    for (int c = 0; c < 1000 && idx1 != 4'd15; c++) begin
      dcnt += int'(done1); step();
    end
    for (int c = 0; c < 200; c++) begin
      if (idx1 != 4'd15) break;
      if (busy1 && !tone1) sil++;
      dcnt += int'(done1);
      step();
    end
    chk("s2_rest", sil, 80);
    chk("s2_wrap", int'({idx1, pitch1, tone1}), 1);
    chk("s2_nodone", dcnt, 0);
    loop_en = 1'b0;
    pulse_stop();

    // Key held inside entry 3.
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 300 && idx1 != 4'd3; c++) step();
    for (int n = 1; n < 15; n++) step();
    key = 8'b0010_0100;
    pc = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (k == 0) chk("s3_key", int'({pitch1, tone1}), 5);
      if (idx1 == 4'd3 && pitch1 == 3'd2 && tone1) pc++;
    end
    key = '0;
    rc = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (idx1 == 4'd3 && pitch1 == 3'd3 && tone1) rc++;
      else break;
    end
    chk("s3_held", pc, 25);
    chk("s3_rest", rc, 25);
    pulse_stop();

    // start+stop together, then stop in a gap.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("s4_both", int'({busy0, busy1}), 0);
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (busy0 && !tone0) break;
      step();
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("s4_stop_gap", int'({busy0, tone0, done0, idx0}), 0);

    // Reset during entry 5.
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 400 && idx1 != 4'd5; c++) step();
    step(); step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("s5_rst_u1", int'({pitch1, tone1, busy1, idx1, done1}), 0);
    chk("s5_rst_u0", int'({pitch0, tone0, busy0, idx0, done0}), 0);
    start = 1'b1; step(); start = 1'b0;
    chk("s5_restart", int'({idx1, pitch1, tone1, busy1}), 3);
    pulse_stop();

`ifdef MELODY_SEQUENCER_TEMPO_EN
    tempo = 2'd2;
    start = 1'b1; step(); start = 1'b0; tempo = 2'd0;
    on0 = 0;
    for (int c = 0; c < 100; c++) begin
      if (!(tone0 && idx0 == 4'd0)) break;
      on0++; step();
    end
    chk("s6_tempo", on0, 8);
    pulse_stop();
`endif

    // Random traffic, checked by the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      step();
      start = ($urandom % 60) == 0;
      stop = ($urandom % 150) == 0;
      if (($urandom % 100) == 0) loop_en = ~loop_en;
      if (($urandom % 40) == 0)
        key = (($urandom % 3) == 0) ? 8'($urandom) : 8'd0;
      rst_n = ($urandom % 500) != 0;
`ifdef MELODY_SEQUENCER_TEMPO_EN
      if (($urandom % 50) == 0) tempo = 2'($urandom);
`endif
    end
    rst_n = 1'b1; key = '0; start = 1'b0; stop = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
